// File: rtl/cms_pkg.sv
// Shared monitoring package: default trace packet geometry, counter width,
// the holding-register state encoding and the trace packet layout.
package cms_pkg;

   localparam int unsigned TRACE_PC_WIDTH    = 64;
   localparam int unsigned TRACE_INSTR_WIDTH = 32;
   localparam int unsigned TRACE_IN_WIDTH    = TRACE_PC_WIDTH + TRACE_INSTR_WIDTH;
   localparam int unsigned TRACE_OUT_WIDTH   = 32;
   localparam int unsigned CNT_WIDTH         = 32;

   // Holding register occupancy.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } hold_state_e;

   // Default trace packet as it appears on S_AXIS_tdata.
   typedef struct packed {
      logic [TRACE_PC_WIDTH-1:0]    pc;
      logic [TRACE_INSTR_WIDTH-1:0] instr;
   } trace_pkt_t;

endpackage

// File: rtl/trace_axis_downsizer.sv
// Splits one wide trace packet into RATIO narrow AXI-Stream beats, least
// significant word first, and counts delivered beats and frames.
//   clk, rst_n            : clock, async active-low reset
//   S_AXIS_*              : wide packet input (tvalid/tready/tdata/tlast)
//   M_AXIS_*              : narrow beat output (tvalid/tready/tdata/tlast)
//   stats_clear           : synchronous clear of both counters
//   beats_sent/frames_sent: wrapping counts of beats / tlast beats delivered
module trace_axis_downsizer
   import cms_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = TRACE_IN_WIDTH,
   parameter int unsigned OUT_WIDTH = TRACE_OUT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 S_AXIS_tvalid,
   output logic                 S_AXIS_tready,
   input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
   input  logic                 S_AXIS_tlast,
   output logic                 M_AXIS_tvalid,
   input  logic                 M_AXIS_tready,
   output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
   output logic                 M_AXIS_tlast,
   input  logic                 stats_clear,
   output logic [CNT_WIDTH-1:0] beats_sent,
   output logic [CNT_WIDTH-1:0] frames_sent
);

   localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int unsigned IDX_W = (RATIO > 2) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   // Refuse geometries that do not split into at least two whole beats.
   if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_ratio
      $error("trace_axis_downsizer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
   end

   hold_state_e                        state, state_nxt;
   logic [IDX_W-1:0]                   idx, idx_nxt;
   logic [RATIO-1:0][OUT_WIDTH-1:0]    holding, holding_nxt;
   logic                               hold_last, hold_last_nxt;
   logic                               on_last, s_xfer, m_xfer;

   // Handshake and beat selection, all derived from registered state.
   always_comb begin
      on_last       = (idx == LAST_IDX);
      M_AXIS_tvalid = (state == ST_HOLD);
      M_AXIS_tdata  = holding[idx];
      M_AXIS_tlast  = hold_last & on_last;
      // Accept a new packet while empty, or as the final beat leaves.
      S_AXIS_tready = (state == ST_EMPTY) | (on_last & M_AXIS_tready);
      s_xfer        = S_AXIS_tvalid & S_AXIS_tready;
      m_xfer        = M_AXIS_tvalid & M_AXIS_tready;
   end

   // Next-state logic for the holding register.
   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      holding_nxt   = holding;
      hold_last_nxt = hold_last;
      if (s_xfer) begin
         // A load always wins: it coincides with the last beat leaving.
         state_nxt     = ST_HOLD;
         idx_nxt       = '0;
         holding_nxt   = S_AXIS_tdata;
         hold_last_nxt = S_AXIS_tlast;
      end else if (m_xfer) begin
         if (on_last) begin
            state_nxt = ST_EMPTY;
            idx_nxt   = '0;
         end else begin
            idx_nxt = idx + IDX_W'(1);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         idx       <= '0;
         holding   <= '0;
         hold_last <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         holding   <= holding_nxt;
         hold_last <= hold_last_nxt;
      end
   end

   // Delivery counters; clear has priority over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beats_sent  <= '0;
         frames_sent <= '0;
      end else if (stats_clear) begin
         beats_sent  <= '0;
         frames_sent <= '0;
      end else begin
         if (m_xfer) begin
            beats_sent <= beats_sent + CNT_WIDTH'(1);
         end
         if (m_xfer && M_AXIS_tlast) begin
            frames_sent <= frames_sent + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_trace_axis_downsizer.sv
// Bench for trace_axis_downsizer: a beats-remaining queue model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_trace_axis_downsizer;

   localparam int unsigned IW = 96;
   localparam int unsigned OW = 32;
   localparam int unsigned R  = IW / OW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_tvalid, s_tready, s_tlast;
   logic [IW-1:0] s_tdata;
   logic          m_tvalid, m_tready, m_tlast;
   logic [OW-1:0] m_tdata;
   logic          stats_clear;
   logic [31:0]   beats_sent, frames_sent;

   trace_axis_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .S_AXIS_tvalid(s_tvalid),
      .S_AXIS_tready(s_tready),
      .S_AXIS_tdata (s_tdata),
      .S_AXIS_tlast (s_tlast),
      .M_AXIS_tvalid(m_tvalid),
      .M_AXIS_tready(m_tready),
      .M_AXIS_tdata (m_tdata),
      .M_AXIS_tlast (m_tlast),
      .stats_clear  (stats_clear),
      .beats_sent   (beats_sent),
      .frames_sent  (frames_sent)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: expected beats of the held packet, still to be delivered.
   logic [OW:0]  q[$];
   int           left = 0;
   logic [31:0]  m_beats = 0, m_frames = 0;
   int           n_delivered = 0;
   bit           rec = 0;
   bit           tv_hist[$], sr_hist[$];

   always @(negedge clk) begin
      bit exp_sr, mx, sx;
      if (!rst_n) begin
         q.delete(); left = 0; m_beats = 0; m_frames = 0;
         chk("reset_outputs", {m_tvalid, m_tlast, m_tdata, beats_sent, frames_sent}, '0);
      end else begin
         exp_sr = (left == 0) || (left == 1 && m_tready);
         chk("s_tready", s_tready, exp_sr);
         chk("m_tvalid", m_tvalid, left != 0);
         if (left != 0) chk("beat", {m_tdata, m_tlast}, q[0]);
         chk("beats_sent", beats_sent, m_beats);
         chk("frames_sent", frames_sent, m_frames);
         if (rec) begin tv_hist.push_back(m_tvalid); sr_hist.push_back(s_tready); end
         // Transfers that will happen at the coming posedge.
         mx = (left != 0) && m_tready;
         sx = s_tvalid && exp_sr;
         if (stats_clear) begin
            m_beats = 0; m_frames = 0;
         end else if (mx) begin
            m_beats++;
            if (q[0][0]) m_frames++;
         end
         if (mx) begin void'(q.pop_front()); left--; n_delivered++; end
         if (sx) begin
            for (int k = 0; k < R; k++)
               q.push_back({s_tdata[k*OW +: OW], s_tlast && (k == R - 1)});
            left = R;
         end
      end
   end

   // Random back-pressure, active only in the random phase.
   bit rand_mode = 0;
   always @(posedge clk) begin
      #1;
      if (rand_mode) m_tready = 1'($urandom % 2);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Called at posedge+1; returns at posedge+1 just after acceptance.
   task automatic push_pkt(input logic [IW-1:0] d, input logic l);
      bit acc;
      s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
      for (int t = 0; t < 200; t++) begin
         #1; acc = s_tready;
         tick();
         if (acc) begin s_tvalid = 1'b0; return; end
      end
      s_tvalid = 1'b0;
      chk("push_timeout", 1'b0, 1'b1);
   endtask

   task automatic drain();
      for (int t = 0; t < 200; t++) begin
         if (!m_tvalid) return;
         tick();
      end
      chk("drain_timeout", 1'b0, 1'b1);
   endtask

   function automatic logic [IW-1:0] rnd_pkt();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [OW-1:0] words[3];
      logic          lasts[3];
      int            got, first, base;

      rst_n = 1'b0; s_tvalid = 0; s_tdata = '0; s_tlast = 0; m_tready = 0; stats_clear = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("tready_after_reset", s_tready, 1'b1);
      chk("tvalid_after_reset", m_tvalid, 1'b0);

      // Single packet {pc=0x80000010, instr=0x13}, tlast, no back-pressure.
      tick();
      m_tready = 1'b1;
      push_pkt({64'h0000_0000_8000_0010, 32'h0000_0013}, 1'b1);
      chk("first_beat_latency", m_tvalid, 1'b1);
      got = 0;
      for (int t = 0; t < 10 && got < 3; t++) begin
         if (m_tvalid && m_tready) begin words[got] = m_tdata; lasts[got] = m_tlast; got++; end
         tick();
      end
      chk("single_nbeats", got, 3);
      chk("single_w0", {words[0], lasts[0]}, {32'h0000_0013, 1'b0});
      chk("single_w1", {words[1], lasts[1]}, {32'h8000_0010, 1'b0});
      chk("single_w2", {words[2], lasts[2]}, {32'h0000_0000, 1'b1});
      chk("single_beats_sent", beats_sent, 32'd3);
      chk("single_frames_sent", frames_sent, 32'd1);

      // Four back-to-back packets: 12 gapless beats, input ready every 3rd.
      tick();
      rec = 1;
      for (int p = 0; p < 4; p++) push_pkt(rnd_pkt(), 1'($urandom % 2));
      drain();
      tick();
      rec = 0;
      first = -1;
      foreach (tv_hist[i]) if (first < 0 && tv_hist[i]) first = i;
      got = 0;
      for (int i = first; i >= 0 && i < tv_hist.size() && tv_hist[i]; i++) got++;
      chk("b2b_run_length", got, 12);
      for (int j = 0; j < 12 && first >= 0 && first + j < sr_hist.size(); j++)
         chk("b2b_s_tready", sr_hist[first + j], (j % 3) == 2);

      // 1000 random packets under 50% back-pressure.
      base = n_delivered;
      rand_mode = 1;
      for (int p = 0; p < 1000; p++) begin
         if ($urandom % 4 == 0) tick();
         push_pkt(rnd_pkt(), 1'($urandom % 2));
      end
      drain();
      chk("random_beat_total", n_delivered - base, 3000);
      rand_mode = 0;
      tick();
      m_tready = 1'b0;

      // Counter wrap from 0xFFFFFFFF.
      force dut.beats_sent = 32'hFFFF_FFFF;
      m_beats = 32'hFFFF_FFFF;
      tick();
      release dut.beats_sent;
      chk("wrap_preload", beats_sent, 32'hFFFF_FFFF);
      m_tready = 1'b1;
      push_pkt(rnd_pkt(), 1'b0);
      tick();
      chk("wrap_to_zero", beats_sent, 32'd0);
      drain();

      // stats_clear coinciding with a tlast transfer.
      push_pkt(rnd_pkt(), 1'b1);
      for (int t = 0; t < 10; t++) begin
         if (m_tvalid && m_tlast) break;
         tick();
      end
      chk("clear_setup_tlast", m_tvalid && m_tlast, 1'b1);
      stats_clear = 1'b1;
      tick();
      stats_clear = 1'b0;
      chk("clear_frames", frames_sent, 32'd0);
      chk("clear_beats", beats_sent, 32'd0);
      tick();

      // Reset after the first beat of a packet.
      push_pkt(rnd_pkt(), 1'b1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_tvalid", m_tvalid, 1'b0);
      chk("rst_mid_tdata", m_tdata, 32'd0);
      chk("rst_mid_tlast", m_tlast, 1'b0);
      chk("rst_mid_counters", {beats_sent, frames_sent}, 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      #1 chk("rst_release_tready", s_tready, 1'b1);
      for (int t = 0; t < 5; t++) begin
         tick();
         chk("rst_no_leftover", m_tvalid, 1'b0);
      end

      // Normal operation resumes after reset.
      push_pkt(rnd_pkt(), 1'b1);
      drain();
      chk("post_reset_beats", beats_sent, 32'd3);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/trace_axis_downsizer.md
TRACE_AXIS_DOWNSIZER -- requirements
Module: trace_axis_downsizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 96, meaning the width of the input trace packet ({pc, instr}).
REQ-002 SHALL have parameter OUT_WIDTH, default 32, meaning the output beat width (DMA stream width).
REQ-003 SHALL have derived constant RATIO = IN_WIDTH/OUT_WIDTH; elaboration SHALL fail unless IN_WIDTH is an integer multiple of OUT_WIDTH and RATIO >= 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port S_AXIS_tvalid, input, 1 bit: input packet valid.
REQ-007 SHALL have port S_AXIS_tready, output, 1 bit: input packet accepted when high together with tvalid.
REQ-008 SHALL have port S_AXIS_tdata, input, IN_WIDTH bits: trace packet.
REQ-009 SHALL have port S_AXIS_tlast, input, 1 bit: packet closes a frame.
REQ-010 SHALL have port M_AXIS_tvalid, output, 1 bit: output beat valid.
REQ-011 SHALL have port M_AXIS_tready, input, 1 bit: downstream accepts beat.
REQ-012 SHALL have port M_AXIS_tdata, output, OUT_WIDTH bits: current beat.
REQ-013 SHALL have port M_AXIS_tlast, output, 1 bit: final beat of a frame.
REQ-014 SHALL have port stats_clear, input, 1 bit: synchronous clear of both counters.
REQ-015 SHALL have port beats_sent, output, 32 bits: count of completed output beats, wrapping.
REQ-016 SHALL have port frames_sent, output, 32 bits: count of completed beats with M_AXIS_tlast high, wrapping.

Function
REQ-017 SHALL hold one packet in a holding register with a valid flag and a beat index 0..RATIO-1; states EMPTY (flag 0) and HOLD (flag 1).
REQ-018 SHALL emit beats least-significant word first: beat k carries holding[k*OUT_WIDTH +: OUT_WIDTH] (default: instr, pc[31:0], pc[63:32]).
REQ-019 SHALL drive M_AXIS_tvalid = holding-valid flag; M_AXIS_tdata/tlast SHALL remain stable while tvalid high and tready low.
REQ-020 SHALL drive M_AXIS_tlast high only on beat RATIO-1 of a packet captured with S_AXIS_tlast high.
REQ-021 SHALL advance the beat index by one on each M_AXIS transfer (tvalid & tready) that is not the last beat.
REQ-022 SHALL drive S_AXIS_tready = ~valid | (index == RATIO-1 & M_AXIS_tready), combinationally.
REQ-023 SHALL, on an S_AXIS transfer, load tdata/tlast into the holding register, set valid, index 0, in the following cycle.
REQ-024 SHALL, when the last beat transfers with no simultaneous S_AXIS transfer, clear valid (HOLD->EMPTY).
REQ-025 SHALL sustain one output beat per cycle with no bubble between packets when input is continuously valid; input throughput = 1 packet per RATIO cycles.
REQ-026 SHALL add latency of exactly one cycle from S_AXIS transfer to first M_AXIS_tvalid.
REQ-027 SHALL increment beats_sent on every M_AXIS transfer and frames_sent on every transfer with M_AXIS_tlast; both SHALL wrap 0xFFFFFFFF->0.
REQ-028 SHALL give stats_clear priority over a simultaneous increment (counter reads 0 next cycle).
REQ-029 SHALL never drop or duplicate a beat under arbitrary tready back-pressure.

Reset
REQ-030 SHALL, while rst_n low, force valid=0, index=0, M_AXIS_tvalid=0, M_AXIS_tlast=0, M_AXIS_tdata=0, beats_sent=0, frames_sent=0, independent of clk.
REQ-031 SHALL drive S_AXIS_tready=1 from the first cycle after rst_n deasserts (EMPTY).
REQ-032 SHALL discard any partially sent packet on reset mid-operation; no remaining beats emitted after release.

Structure
REQ-033 SHALL take default IN_WIDTH/OUT_WIDTH and the 32-bit counter width from the shared monitoring package cms_pkg.
REQ-034 SHALL be a single module with no sub-modules.

Verification
REQ-035 Bench SHALL: one packet {pc=0x80000010, instr=0x00000013}, tlast=1, tready=1 -> beats 0x00000013, 0x80000010, 0x00000000, tlast only on third, frames_sent=1, beats_sent=3.
REQ-036 Bench SHALL: 4 back-to-back packets, tready=1 -> 12 consecutive valid beats, no gap, S_AXIS_tready high every 3rd cycle.
REQ-037 Bench SHALL: random tready (50%) over 1000 packets -> output word stream equals scoreboard, no loss/duplication.
REQ-038 Bench SHALL: preload beats_sent=0xFFFFFFFF via 2^32-1 transfers (or forced) then one beat -> beats_sent=0.
REQ-039 Bench SHALL: stats_clear asserted in same cycle as tlast transfer -> frames_sent=0 next cycle.
REQ-040 Bench SHALL: rst_n low after beat 1 of a packet -> M_AXIS_tvalid=0 immediately, no remaining beats after release, S_AXIS_tready=1.
